sa_cache: RTL and testbench

Parametrised set-associative cache tag model with true-LRU replacement and hit/miss statistics. It is the successor to the direct-mapped hit/miss counter, generalised in sets, ways, block size and miss latency. It adds a valid/ready request handshake, a per-request response and a flush. It holds tags only, no data, and sits beside the memory-access stream of the processor model to measure cache behaviour.

---
 rtl/sa_cache_pkg.sv | 24 ++
 rtl/sa_cache_lru.sv | 42 ++++
 rtl/sa_cache.sv | 182 ++++++++++++++++++
 tb/tb_sa_cache.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_cache_pkg.sv
// Shared types for the sa_cache set-associative tag model.
// Optional eviction counter in sa_cache is enabled by SA_CACHE_EVICT_CNT_EN.
package sa_cache_pkg;

  // Tags are zero-extended into a fixed-width field so the line record can live here.
  localparam int unsigned TagMaxW = 64;

  typedef enum logic [1:0] {StIdle, StLookup, StRefill, StResp} state_e;

  typedef struct packed {
    logic               valid;
    logic [TagMaxW-1:0] tag;
  } line_t;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sa_cache_lru.sv
// Per-set true-LRU logic: age update for a touched way and victim selection.
// Ages are packed WAY_W bits per way; age 0 is the most recently used way.
module sa_cache_lru #(
  parameter int unsigned WAYS  = 4,
  parameter int unsigned WAY_W = 2
) (
  input  logic [WAYS*WAY_W-1:0] ages,
  input  logic [WAYS-1:0]       valid,
  input  logic [WAY_W-1:0]      touch_way,
  output logic [WAYS*WAY_W-1:0] ages_new,
  output logic [WAY_W-1:0]      victim
);

  logic [WAY_W-1:0] ref_age;

  always_comb begin
    ref_age = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touch_way) ref_age = ages[w*WAY_W +: WAY_W];
    end
    ages_new = ages;
    for (int w = 0; w < WAYS; w++) begin
      if (WAY_W'(w) == touch_way) begin
        ages_new[w*WAY_W +: WAY_W] = '0;
      end else if (ages[w*WAY_W +: WAY_W] < ref_age) begin
        ages_new[w*WAY_W +: WAY_W] = ages[w*WAY_W +: WAY_W] + 1'b1;
      end
    end
  end

  // Descending scans so the lowest index wins; an invalid way overrides the oldest.
  always_comb begin
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (ages[w*WAY_W +: WAY_W] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) victim = WAY_W'(w);
    end
  end

endmodule

// File: rtl/sa_cache.sv
// Set-associative cache tag model with true-LRU replacement and hit/miss statistics.
// Define SA_CACHE_EVICT_CNT_EN to add the evict_count output.
module sa_cache
  import sa_cache_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned SETS        = 16,
  parameter int unsigned WAYS        = 4,
  parameter int unsigned BLOCK_BYTES = 16,
  parameter int unsigned MISS_LAT    = 4,
  parameter int unsigned CNT_W       = 32,
  localparam int unsigned OFF_W      = clog2(BLOCK_BYTES),
  localparam int unsigned IDX_W      = clog2(SETS),
  localparam int unsigned TAG_W      = ADDR_W - IDX_W - OFF_W,
  localparam int unsigned WAY_W      = clog2(WAYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [WAY_W-1:0]  resp_way,
  output logic              busy,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
`ifdef SA_CACHE_EVICT_CNT_EN
  ,
  output logic [CNT_W-1:0]  evict_count
`endif
);

  localparam int unsigned WAIT_W = clog2(MISS_LAT) + 1;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q;
  logic [WAY_W-1:0]      victim_q, resp_way_q;
  logic                  resp_hit_q;
  logic [WAIT_W-1:0]     wait_q;
  logic [CNT_W-1:0]      hit_count_q, miss_count_q;
  line_t                 lines_q [SETS][WAYS];
  logic [WAYS*WAY_W-1:0] ages_q [SETS];

  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic [TagMaxW-1:0]    tag_ext;
  logic                  unused_off;

  assign idx        = addr_q[OFF_W +: IDX_W];
  assign tag        = addr_q[ADDR_W-1 -: TAG_W];
  assign tag_ext    = TagMaxW'(tag);
  assign unused_off = ^addr_q[OFF_W-1:0];

  logic [WAYS-1:0]       set_valid;
  logic                  hit;
  logic [WAY_W-1:0]      hit_way, touch_way, victim;
  logic [WAYS*WAY_W-1:0] ages_new;

  always_comb begin
    set_valid = '0;
    hit       = 1'b0;
    hit_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = lines_q[idx][w].valid;
      if (lines_q[idx][w].valid && (lines_q[idx][w].tag == tag_ext)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Lookup touches the hit way; refill touches the way chosen at lookup.
  assign touch_way = (state_q == StLookup) ? hit_way : victim_q;

  sa_cache_lru #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .ages      (ages_q[idx]),
    .valid     (set_valid),
    .touch_way (touch_way),
    .ages_new  (ages_new),
    .victim    (victim)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (!flush && req_valid) state_d = StLookup;
      StLookup: state_d = hit ? StResp : StRefill;
      StRefill: if (wait_q == '0) state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      victim_q     <= '0;
      resp_way_q   <= '0;
      resp_hit_q   <= 1'b0;
      wait_q       <= '0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          lines_q[s][w]                  <= '0;
          ages_q[s][w*WAY_W +: WAY_W]    <= WAY_W'(w);
        end
      end
    end else begin
      state_q <= state_d;
      unique case (state_q)
        StIdle: begin
          if (flush) begin
            for (int s = 0; s < SETS; s++) begin
              for (int w = 0; w < WAYS; w++) begin
                lines_q[s][w].valid           <= 1'b0;
                ages_q[s][w*WAY_W +: WAY_W]   <= WAY_W'(w);
              end
            end
          end else if (req_valid) begin
            addr_q <= req_addr;
          end
        end
        StLookup: begin
          if (hit) begin
            hit_count_q <= hit_count_q + CNT_W'(1);
            ages_q[idx] <= ages_new;
            resp_hit_q  <= 1'b1;
            resp_way_q  <= hit_way;
          end else begin
            miss_count_q <= miss_count_q + CNT_W'(1);
            victim_q     <= victim;
            wait_q       <= WAIT_W'(MISS_LAT - 1);
          end
        end
        StRefill: begin
          if (wait_q == '0) begin
            lines_q[idx][victim_q].valid <= 1'b1;
            lines_q[idx][victim_q].tag   <= tag_ext;
            ages_q[idx]                  <= ages_new;
            resp_hit_q                   <= 1'b0;
            resp_way_q                   <= victim_q;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        StResp: ;
        default: ;
      endcase
    end
  end

  // Held low while in reset so the requester cannot see a ready pulse before release.
  assign req_ready  = rst_n && (state_q == StIdle) && !flush;
  assign resp_valid = (state_q == StResp);
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign busy       = (state_q != StIdle);
  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

`ifdef SA_CACHE_EVICT_CNT_EN
  logic [CNT_W-1:0] evict_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evict_count_q <= '0;
    end else if ((state_q == StLookup) && !hit && set_valid[victim]) begin
      evict_count_q <= evict_count_q + CNT_W'(1);
    end
  end

  assign evict_count = evict_count_q;
`endif

endmodule

// File: tb/tb_sa_cache.sv
// Self-checking bench for sa_cache: directed vector table, corner sequences and a random
// phase against a recency-list reference model. Honours SA_CACHE_EVICT_CNT_EN.
module tb_sa_cache;

  localparam int MissLat = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        req_ready, resp_valid, resp_hit, busy;
  logic [1:0]  resp_way;
  logic [31:0] hit_count, miss_count;
`ifdef SA_CACHE_EVICT_CNT_EN
  logic [31:0] evict_count;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sa_cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_way   (resp_way),
    .busy       (busy),
    .hit_count  (hit_count),
    .miss_count (miss_count)
`ifdef SA_CACHE_EVICT_CNT_EN
    ,
    .evict_count(evict_count)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per set, a recency list of ways (index 0 = most recent).
  bit          mv  [16][4];
  logic [23:0] mt  [16][4];
  int          ord [16][4];
  int          m_hits, m_misses, m_evicts;

  function automatic void m_clear();
    for (int s = 0; s < 16; s++)
      for (int i = 0; i < 4; i++) begin
        mv[s][i]  = 1'b0;
        ord[s][i] = i;
      end
  endfunction

  function automatic void m_access(input logic [31:0] a, output bit h, output int way);
    int s;
    int p;
    logic [23:0] t;
    s = int'(a[7:4]);
    t = a[31:8];
    h = 1'b0;
    way = -1;
    for (int i = 0; i < 4; i++)
      if (mv[s][i] && mt[s][i] == t) begin
        h = 1'b1;
        way = i;
      end
    if (h) m_hits++;
    else begin
      m_misses++;
      for (int i = 3; i >= 0; i--) if (!mv[s][i]) way = i;
      if (way < 0) begin
        way = ord[s][3];
        m_evicts++;
      end
      mv[s][way] = 1'b1;
      mt[s][way] = t;
    end
    p = 0;
    for (int i = 0; i < 4; i++) if (ord[s][i] == way) p = i;
    for (int i = p; i > 0; i--) ord[s][i] = ord[s][i-1];
    ord[s][0] = way;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req_valid = 1'b0;
    flush = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    m_hits = 0;
    m_misses = 0;
    m_evicts = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 1, 0);
  endtask

  // Issues one request; returns response fields and edges from acceptance to resp_valid.
  task automatic do_req(input logic [31:0] a, output logic h, output logic [1:0] w,
                        output int lat);
    int n;
    n = 0;
    h = 1'b0;
    w = '0;
    lat = 0;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("ready_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_addr = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr = $urandom;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!resp_valid && lat < 50);
    h = resp_hit;
    w = resp_way;
  endtask

  typedef struct {
    bit          rst;
    logic [31:0] addr;
    bit          hit;
    int          way;
    int          lat;
    int          hits;
    int          misses;
    int          evicts;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic h;
    logic [1:0] w;
    int lat;
    bit mh;
    int mw;
    bool_seen_t: begin end

    // Group A: basic miss/hit and a second set.
    vecs.push_back('{1, 32'h35A, 0, 0, 1 + MissLat, 0, 1, 0});
    vecs.push_back('{0, 32'h35A, 1, 0, 1,           1, 1, 0});
    vecs.push_back('{1, 32'h35A, 0, 0, 1 + MissLat, 0, 1, 0});
    vecs.push_back('{0, 32'h8B9, 0, 0, 1 + MissLat, 0, 2, 0});
    vecs.push_back('{0, 32'h35A, 1, 0, 1,           1, 2, 0});
    // Group B: fill set 5, then LRU eviction.
    vecs.push_back('{1, 32'h05A, 0, 0, 1 + MissLat, 0, 1, 0});
    vecs.push_back('{0, 32'h15A, 0, 1, 1 + MissLat, 0, 2, 0});
    vecs.push_back('{0, 32'h25A, 0, 2, 1 + MissLat, 0, 3, 0});
    vecs.push_back('{0, 32'h35A, 0, 3, 1 + MissLat, 0, 4, 0});
    vecs.push_back('{0, 32'h05A, 1, 0, 1,           1, 4, 0});
    vecs.push_back('{0, 32'h45A, 0, 1, 1 + MissLat, 1, 5, 1});
    vecs.push_back('{0, 32'h15A, 0, 2, 1 + MissLat, 1, 6, 2});
    // Group C: offset bits do not matter.
    vecs.push_back('{1, 32'h350, 0, 0, 1 + MissLat, 0, 1, 0});
    vecs.push_back('{0, 32'h35F, 1, 0, 1,           1, 1, 0});

    // Values while reset is held.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_hit", resp_hit, 0);
    check("rst_resp_way", resp_way, 0);
    check("rst_busy", busy, 0);
    check("rst_hit_count", hit_count, 0);
    check("rst_miss_count", miss_count, 0);
`ifdef SA_CACHE_EVICT_CNT_EN
    check("rst_evict_count", evict_count, 0);
`endif
    rst_n = 1'b1;
    #1;
    check("post_rst_ready", req_ready, 1);

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      do_req(vecs[i].addr, h, w, lat);
      check($sformatf("vec%0d_hit", i), h, vecs[i].hit);
      check($sformatf("vec%0d_way", i), w, vecs[i].way);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_hits", i), hit_count, vecs[i].hits);
      check($sformatf("vec%0d_misses", i), miss_count, vecs[i].misses);
`ifdef SA_CACHE_EVICT_CNT_EN
      check($sformatf("vec%0d_evicts", i), evict_count, vecs[i].evicts);
`endif
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_pulse", i), resp_valid, 0);
    end

    // Flush: ready drops during the flush cycle, lines are lost, counters kept.
    apply_reset();
    do_req(32'h35A, h, w, lat);
    do_req(32'h35A, h, w, lat);
    check("flush_pre_hit", h, 1);
    wait_idle();
    flush = 1'b1;
    #1;
    check("flush_ready_low", req_ready, 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", busy, 0);
    do_req(32'h35A, h, w, lat);
    check("flush_miss", h, 0);
    check("flush_way", w, 0);
    check("flush_hits", hit_count, 1);
    check("flush_misses", miss_count, 2);

    // Reset during refill aborts the access.
    apply_reset();
    @(negedge clk);
    req_valid = 1'b1;
    req_addr = 32'h35A;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrefill_busy", busy, 1);
    rst_n = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      repeat (6) begin
        @(negedge clk);
        if (resp_valid) seen = 1'b1;
      end
      check("midrefill_no_resp", seen, 0);
    end
    check("midrefill_misses", miss_count, 0);
    check("midrefill_hits", hit_count, 0);
    rst_n = 1'b1;
    do_req(32'h35A, h, w, lat);
    check("midrefill_after_hit", h, 0);
    check("midrefill_after_lat", lat, 1 + MissLat);
    check("midrefill_after_misses", miss_count, 1);

    // Random phase against the reference model.
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 19) == 0) begin
        wait_idle();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        m_clear();
      end else begin
        logic [31:0] a;
        a = ($urandom_range(0, 5) << 8) | ($urandom_range(0, 15) << 4) | $urandom_range(0, 15);
        m_access(a, mh, mw);
        do_req(a, h, w, lat);
        check($sformatf("rnd%0d_hit", i), h, mh);
        check($sformatf("rnd%0d_way", i), w, mw);
        check($sformatf("rnd%0d_lat", i), lat, mh ? 1 : 1 + MissLat);
      end
    end
    wait_idle();
    check("rnd_hits", hit_count, m_hits);
    check("rnd_misses", miss_count, m_misses);
`ifdef SA_CACHE_EVICT_CNT_EN
    check("rnd_evicts", evict_count, m_evicts);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
